// File: rtl/nios_core_timer_pkg.sv
// Shared types and constants for the interval-timer job sequencer.
// Timer slave register map, control bits and sequencer states.
package nios_core_timer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_WAIT_IRQ,
    S_CLR_STAT,
    S_STOP,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [15:0] CTRL_RUN_WORD =
    16'((1 << CTRL_ITO) | (1 << CTRL_CONT) | (1 << CTRL_START));
  localparam logic [15:0] CTRL_STOP_WORD = 16'(1 << CTRL_STOP);

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  localparam bus_t BUS_IDLE = '{
    cs: 1'b0, write_n: 1'b1, addr: 3'd0, data: 16'h0000
  };

  // Bus cycle issued while the sequencer sits in state s.
  function automatic bus_t bus_for(state_t s, logic [31:0] period);
    bus_t b;
    b = BUS_IDLE;
    unique case (s)
      S_WR_PL:    b = '{1'b1, 1'b0, ADDR_PERIOD_L, period[15:0]};
      S_WR_PH:    b = '{1'b1, 1'b0, ADDR_PERIOD_H, period[31:16]};
      S_WR_CTRL:  b = '{1'b1, 1'b0, ADDR_CONTROL, CTRL_RUN_WORD};
      S_CLR_STAT: b = '{1'b1, 1'b0, ADDR_STATUS, 16'h0000};
      S_FLUSH:    b = '{1'b1, 1'b0, ADDR_STATUS, 16'h0000};
      S_STOP:     b = '{1'b1, 1'b0, ADDR_CONTROL, CTRL_STOP_WORD};
      default:    b = BUS_IDLE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nios_core_timer_seq.sv
// Runs a timer job: programs period, counts timeouts, then stops the timer.
// All outputs except cmd_ready are registered from the next state.
module nios_core_timer_seq
  import nios_core_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_period,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [2:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [15:0]      m_writedata,
  input  logic             timer_irq,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [CNT_W-1:0] ticks_done
);

  state_t           state, state_nxt;
  logic [31:0]      period, period_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] ticks_nxt;
  bus_t             bus_nxt;

  assign cmd_ready = (state == S_IDLE) && !reset;

  always_comb begin
    state_nxt  = state;
    period_nxt = period;
    count_nxt  = count;
    ticks_nxt  = ticks_done;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          period_nxt = (cmd_period == 32'd0) ? 32'd1 : cmd_period;
          count_nxt  = cmd_count;
          ticks_nxt  = '0;
          state_nxt  = (cmd_count == '0) ? S_DONE : S_WR_PL;
        end
      end
      S_WR_PL:   state_nxt = abort ? S_STOP : S_WR_PH;
      S_WR_PH:   state_nxt = abort ? S_STOP : S_WR_CTRL;
      S_WR_CTRL: state_nxt = abort ? S_STOP : S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        // Abort wins: a coincident timeout is left for FLUSH to clear.
        if (abort) begin
          state_nxt = S_STOP;
        end else if (timer_irq) begin
          state_nxt = S_CLR_STAT;
          if (ticks_done != '1)
            ticks_nxt = ticks_done + CNT_W'(1);
        end
      end
      S_CLR_STAT: begin
        if (abort || ticks_done == count)
          state_nxt = S_STOP;
        else
          state_nxt = S_WAIT_IRQ;
      end
      S_STOP:  state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus_nxt = bus_for(state_nxt, period_nxt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      period       <= '0;
      count        <= '0;
      ticks_done   <= '0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= '0;
      m_writedata  <= '0;
      busy         <= 1'b0;
      tick         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      period       <= period_nxt;
      count        <= count_nxt;
      ticks_done   <= ticks_nxt;
      m_chipselect <= bus_nxt.cs;
      m_write_n    <= bus_nxt.write_n;
      m_address    <= bus_nxt.addr;
      m_writedata  <= bus_nxt.data;
      busy         <= (state_nxt != S_IDLE);
      tick         <= (state_nxt == S_CLR_STAT);
      done         <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_nios_core_timer_seq.sv
// Directed bench for nios_core_timer_seq.
// Expected bus writes are queued at stimulus time and popped by a monitor.
module tb_nios_core_timer_seq;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_period = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             abort = 1'b0;
  logic [2:0]       m_address;
  logic             m_chipselect;
  logic             m_write_n;
  logic [15:0]      m_writedata;
  logic             timer_irq = 1'b0;
  logic             busy;
  logic             tick;
  logic             done;
  logic [CNT_W-1:0] ticks_done;

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  logic [18:0] exp_q[$];

  nios_core_timer_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_count(cmd_count),
    .abort(abort),
    .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata),
    .timer_irq(timer_irq),
    .busy(busy), .tick(tick), .done(done),
    .ticks_done(ticks_done)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(logic [2:0] a, logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push_setup(logic [31:0] p);
    push_wr(3'd2, p[15:0]);
    push_wr(3'd3, p[31:16]);
    push_wr(3'd1, 16'h0007);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write must match the scoreboard; idle bus must be clean.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_chipselect === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {13'd0, m_address, m_writedata}, 32'hFFFF_FFFF);
        end else begin
          logic [18:0] e;
          e = exp_q.pop_front();
          check("wr_strobe", {31'd0, m_write_n}, 32'd0);
          check("wr_addr_data", {13'd0, m_address, m_writedata}, {13'd0, e});
        end
      end else begin
        check("bus_idle", {12'd0, m_write_n, m_address, m_writedata},
              {12'd0, 1'b1, 3'd0, 16'd0});
      end
    end
  end

  task automatic start_job(logic [31:0] p, logic [CNT_W-1:0] c);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    check("ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_period = p;
    cmd_count = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // From WAIT_IRQ: raise irq one cycle, land in CLR_STAT, then step once more.
  task automatic irq_tick(int k, bit last);
    push_wr(3'd0, 16'h0000);
    if (last) begin
      push_wr(3'd1, 16'h0008);
      push_wr(3'd0, 16'h0000);
    end
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
    check("tick_pulse", {31'd0, tick}, 32'd1);
    check("ticks_inc", {16'd0, ticks_done}, k);
    step();
    check("tick_low", {31'd0, tick}, 32'd0);
    repeat (2) begin
      if (!last) step();
    end
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    mon_en = 1'b1;
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_tick", {30'd0, done, tick}, 32'd0);
    check("rst_ticks", {16'd0, ticks_done}, 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Normal job: 3 timeouts.
    push_setup(32'h0001_86A0);
    start_job(32'h0001_86A0, 16'd3);
    check("busy_job1", {31'd0, busy}, 32'd1);
    repeat (5) step();
    irq_tick(1, 1'b0);
    irq_tick(2, 1'b0);
    irq_tick(3, 1'b1);
    step();
    step();
    check("done_job1", {31'd0, done}, 32'd1);
    check("done_busy_job1", {31'd0, busy}, 32'd1);
    step();
    check("done_drop_job1", {31'd0, done}, 32'd0);
    check("idle_busy_job1", {31'd0, busy}, 32'd0);
    check("ticks_job1", {16'd0, ticks_done}, 32'd3);

    // Zero-count job.
    start_job(32'h0000_0100, 16'd0);
    check("done_cnt0", {31'd0, done}, 32'd1);
    step();
    check("done_drop_cnt0", {31'd0, done}, 32'd0);
    check("ticks_cnt0", {16'd0, ticks_done}, 32'd0);

    // Abort coincident with irq after 2 ticks.
    push_setup(32'd10);
    start_job(32'd10, 16'd5);
    repeat (3) step();
    irq_tick(1, 1'b0);
    irq_tick(2, 1'b0);
    push_wr(3'd1, 16'h0008);
    push_wr(3'd0, 16'h0000);
    abort = 1'b1;
    timer_irq = 1'b1;
    step();
    abort = 1'b0;
    timer_irq = 1'b0;
    check("abort_no_tick", {31'd0, tick}, 32'd0);
    check("abort_ticks", {16'd0, ticks_done}, 32'd2);
    step();
    step();
    check("done_abort", {31'd0, done}, 32'd1);
    step();
    check("ticks_abort", {16'd0, ticks_done}, 32'd2);

    // cmd_valid held while busy.
    push_setup(32'd5);
    start_job(32'd5, 16'd1);
    cmd_valid = 1'b1;
    cmd_count = 16'd0;
    check("ready_busy", {31'd0, cmd_ready}, 32'd0);
    repeat (3) step();
    check("ready_wait_irq", {31'd0, cmd_ready}, 32'd0);
    irq_tick(1, 1'b1);
    step();
    step();
    check("ready_in_done", {31'd0, cmd_ready}, 32'd0);
    check("done_hold", {31'd0, done}, 32'd1);
    step();
    check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    check("done_reaccept", {31'd0, done}, 32'd1);
    check("ticks_reaccept", {16'd0, ticks_done}, 32'd0);
    step();

    // Reset while writing period_h.
    push_wr(3'd2, 16'h5678);
    push_wr(3'd3, 16'h1234);
    start_job(32'h1234_5678, 16'd2);
    step();
    reset = 1'b1;
    step();
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_cs", {31'd0, m_chipselect}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (3) begin
      step();
      check("no_done_after_rst", {31'd0, done}, 32'd0);
    end

    // Period 0 clamps to 1.
    push_setup(32'd1);
    start_job(32'd0, 16'd1);
    repeat (3) step();
    irq_tick(1, 1'b1);
    step();
    step();
    check("done_p0", {31'd0, done}, 32'd1);
    step();
    step();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
